// File: rtl/multi_rate_ticker.sv
// multi_rate_ticker
//   Multi-channel tick / clock-enable generator. Every channel has its own
//   runtime divide value D and mode. A running channel emits a one-cycle
//   tick every D+1 clk cycles and toggles a square-wave level on each tick,
//   so downstream timers run in the clk domain with no derived clocks.
//   A global pause freezes every channel while preserving phase.
//
//   Mode table (per channel)
//     mode          | meaning
//     MODE_STOP     | counter held at 0, no ticks, level holds, busy low
//     MODE_PERIODIC | tick every D+1 cycles, level toggles on each tick
//     MODE_ONESHOT  | first terminal count ticks once, then drops to stop
//     MODE_SQUARE   | same port behaviour as periodic (reset default)
//
//   Ports
//     clk       in              system clock
//     reset     in              asynchronous, active-high reset
//     pause     in              global freeze, tick forced low while high
//     cfg_we    in              config write strobe
//     cfg_ch    in  [CH_W]      channel addressed by cfg_we
//     cfg_div   in  [CNT_W]     new divide value D
//     cfg_mode  in  [2]         new mode
//     sync_clr  in  [NUM_CH]    per-channel phase restart (div/mode kept)
//     tick      out [NUM_CH]    one-cycle pulse per terminal count
//     level     out [NUM_CH]    square output, toggles on each tick
//     busy      out [NUM_CH]    channel mode is not stop
module multi_rate_ticker #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(9990000),
  parameter logic [1:0]       RESET_MODE  = 2'd3,
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {
    MODE_STOP     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_SQUARE   = 2'd3
  } mode_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             tick_q;
    logic             level_q;
    logic             cfg_hit;

    // Channel indices at or above NUM_CH never match, so such writes are dropped.
    assign cfg_hit = cfg_we && (int'(cfg_ch) == i);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mode_q  <= mode_e'(RESET_MODE);
        cnt_q   <= '0;
        div_q   <= DEFAULT_DIV;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
      end else if (cfg_hit) begin
        mode_q  <= mode_e'(cfg_mode);
        div_q   <= cfg_div;
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
      end else if (sync_clr[i]) begin
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
      end else if (pause) begin
        // Counter frozen so the phase resumes exactly on release.
        tick_q  <= 1'b0;
      end else begin
        case (mode_q)
          MODE_STOP: begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
          end
          MODE_PERIODIC, MODE_SQUARE, MODE_ONESHOT: begin
            if (cnt_q == div_q) begin
              cnt_q   <= '0;
              tick_q  <= 1'b1;
              level_q <= ~level_q;
              // One-shot retires on the same edge that raises its only tick.
              if (mode_q == MODE_ONESHOT) mode_q <= MODE_STOP;
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              tick_q <= 1'b0;
            end
          end
          default: begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
          end
        endcase
      end
    end

    assign tick[i]  = tick_q;
    assign level[i] = level_q;
    assign busy[i]  = (mode_q != MODE_STOP);
  end

endmodule
